// File: rtl/reg_bank_write_arbiter.sv
// Round-robin write arbiter for a bank of enable-gated registers.
// One registered write per cycle; a bounded lock lets the current owner
// keep the bank for up to MAX_LOCK consecutive grants.
module reg_bank_write_arbiter #(
    parameter int WORD_LENGTH = 16,
    parameter int NUM_REQ     = 4,
    parameter int NUM_REGS    = 8,
    parameter int ADDR_WIDTH  = 3,
    parameter int MAX_LOCK    = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ-1:0]             lock,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  addr,
    input  logic [NUM_REQ*WORD_LENGTH-1:0] data,
    output logic [NUM_REQ-1:0]             grant,
    output logic [NUM_REGS-1:0]            reg_enable,
    output logic [WORD_LENGTH-1:0]         reg_data,
    output logic                           addr_err,
    output logic                           locked
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_LOCK + 1);

    typedef enum logic [1:0] {IDLE, GRANT, LOCK} state_t;

    state_t                 state;
    logic [PTR_W-1:0]       ptr;
    logic [PTR_W-1:0]       owner;
    logic [CNT_W-1:0]       lock_cnt;

    logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]  addr_v;
    logic [NUM_REQ-1:0][WORD_LENGTH-1:0] data_v;
    logic [NUM_REQ-1:0]     elig;
    logic                   lock_go;
    logic                   rr_found;
    logic [PTR_W-1:0]       rr_win;
    logic [PTR_W-1:0]       cand;
    logic [PTR_W-1:0]       sel;
    logic [PTR_W-1:0]       ptr_next;
    logic [ADDR_WIDTH-1:0]  sel_addr;
    logic                   addr_bad;
    logic                   any_grant;

    assign addr_v = addr;
    assign data_v = data;

    // A requester granted this cycle sits out the next one unless it continues a lock.
    assign elig = req & ~grant;

    // The owner keeps the bank while it asks for it and the lock budget remains.
    assign lock_go = (state != IDLE) && req[owner] && lock[owner] &&
                     (lock_cnt < CNT_W'(MAX_LOCK));

    // First eligible requester at or after ptr, wrapping around.
    always_comb begin
        rr_found = 1'b0;
        rr_win   = '0;
        cand     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = PTR_W'((int'(ptr) + k) % NUM_REQ);
            if (!rr_found && elig[cand]) begin
                rr_found = 1'b1;
                rr_win   = cand;
            end
        end
    end

    assign sel       = lock_go ? owner : rr_win;
    assign any_grant = lock_go | rr_found;
    assign sel_addr  = addr_v[sel];
    assign addr_bad  = (int'(sel_addr) >= NUM_REGS);
    assign ptr_next  = (rr_win == PTR_W'(NUM_REQ - 1)) ? '0 : rr_win + 1'b1;

    // Arbitration FSM with registered write-port outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            ptr        <= '0;
            owner      <= '0;
            lock_cnt   <= '0;
            grant      <= '0;
            reg_enable <= '0;
            reg_data   <= '0;
            addr_err   <= 1'b0;
            locked     <= 1'b0;
        end else if (!any_grant) begin
            state      <= IDLE;
            lock_cnt   <= '0;
            grant      <= '0;
            reg_enable <= '0;
            addr_err   <= 1'b0;
            locked     <= 1'b0;
        end else begin
            owner      <= sel;
            grant      <= NUM_REQ'(1) << sel;
            // Out-of-range address still acknowledges the requester but writes nothing.
            reg_enable <= addr_bad ? '0 : (NUM_REGS'(1) << sel_addr);
            reg_data   <= data_v[sel];
            addr_err   <= addr_bad;
            if (lock_go) begin
                state    <= LOCK;
                locked   <= 1'b1;
                lock_cnt <= lock_cnt + 1'b1;
            end else begin
                state    <= GRANT;
                locked   <= 1'b0;
                lock_cnt <= CNT_W'(1);
                ptr      <= ptr_next;
            end
        end
    end

endmodule

// File: doc/reg_bank_write_arbiter.md
# reg_bank_write_arbiter

Round-robin write arbiter that shares the write side of a bank of NUM_REGS enable-gated data registers among NUM_REQ requesters. Each cycle it selects at most one pending request and drives the selected register's one-hot load enable and the shared data bus. It returns a one-cycle grant/acknowledge to the winner. A bounded lock lets one requester perform back-to-back writes without starving the others.

## Interface
- WORD_LENGTH, 16, data width of each register and of the shared data bus
- NUM_REQ, 4, number of requesters (2..8)
- NUM_REGS, 8, number of registers in the bank (1..2^ADDR_WIDTH)
- ADDR_WIDTH, 3, register address width
- MAX_LOCK, 4, maximum consecutive grants to one locked requester (≥1)

- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; sampled on rising clk edge
- req  in  NUM_REQ  per-requester write request
- lock  in  NUM_REQ  per-requester request to keep ownership after the current grant
- addr  in  NUM_REQ*ADDR_WIDTH  packed target addresses; requester i uses slice [i*ADDR_WIDTH +: ADDR_WIDTH]
- data  in  NUM_REQ*WORD_LENGTH  packed write data; requester i uses slice [i*WORD_LENGTH +: WORD_LENGTH]
- grant  out  NUM_REQ  registered one-hot; acknowledges that this cycle's write belongs to requester i
- reg_enable  out  NUM_REGS  registered one-hot load enable to the register bank
- reg_data  out  WORD_LENGTH  registered write data to the register bank
- addr_err  out  1  registered pulse: granted address is ≥ NUM_REGS
- locked  out  1  registered; current grant is part of a lock sequence

## Operation
- Arbitration is computed combinationally from the inputs. Results are registered into grant, reg_enable, reg_data, and addr_err.
- Eligibility: req[i]=1, and grant[i] is not currently high. Exception: a locked continuation is eligible while grant[i] is high.
  - A requester holding req continuously without lock is therefore granted at most every other cycle.
- Round-robin pointer ptr:
  - Search starts at ptr and wraps modulo NUM_REQ.
  - After a non-lock grant to i, ptr becomes (i+1) mod NUM_REQ.
  - Reset value of ptr is 0.
- States:
  - IDLE: no grant output.
  - GRANT: a single grant is output.
  - LOCK: owner holds the bank.
- Transitions:
  - IDLE → GRANT when any requester is eligible; otherwise stay in IDLE.
  - GRANT/LOCK → LOCK when the granted requester o has req[o]=1 and lock[o]=1, and lock_cnt < MAX_LOCK. Requester o is granted again regardless of other requesters.
  - GRANT/LOCK → GRANT to a different or the same eligible requester, using round-robin, when the lock condition fails.
  - GRANT/LOCK → IDLE when no requester is eligible.
- lock_cnt:
  - Counts consecutive grants to the same owner.
  - Set to 1 on a fresh grant; increments on each LOCK continuation.
  - When lock_cnt reaches MAX_LOCK, the lock is forced released. ptr advances past the owner. The owner competes normally from the next cycle and is masked for one cycle, as a non-lock grant.
- Address error: if the granted addr ≥ NUM_REGS, then grant still pulses, reg_enable is all zero, and addr_err=1. No register is written.
- reg_data holds its last value when no grant is issued. Only reg_enable qualifies the data.

## Timing
- Reset: grant=0, reg_enable=0, reg_data=0, addr_err=0, locked=0, ptr=0, lock_cnt=0, state IDLE. Reset mid-sequence:
  - Drops any grant or lock on the next edge.
  - Pending requests are re-arbitrated from ptr=0 after reset deasserts.
- Latency: req sampled high at edge N produces grant/reg_enable/reg_data valid during cycle N→N+1. The register bank captures at edge N+1.
- Requester obligations:
  - Hold addr and data stable from raising req until the cycle in which its grant is high.
  - Drop req, or present new addr/data, on the edge after the grant.
- Throughput: one write per cycle across different requesters. Back-to-back writes from a single requester require lock.
- Simultaneous requests: the winner is the first eligible index at or after ptr. There is no fixed priority beyond this.
- lock asserted without req is ignored. lock on a cycle when the requester is not granted has no effect.

## Test plan
- Single write: after reset, req[2]=1, addr=5, data=16'hA5A5 for one cycle → next cycle grant=4'b0100, reg_enable=8'h20, reg_data=16'hA5A5, addr_err=0, locked=0.
- Fairness: req=4'b1111 held constant, no lock, from reset → grants 0,1,2,3,0,... on consecutive cycles; each grant appears exactly once per 4 cycles.
- Lock bound: req[1]=1 and lock[1]=1 held, req[3]=1 held, MAX_LOCK=4 → grant[1] for 4 consecutive cycles with locked=0,1,1,1, then grant[3]; requester 1 is not granted in that cycle.
- Single requester without lock: req[0]=1 held, others 0 → grant[0] is high on alternating cycles (1,0,1,0).
- Address error: NUM_REGS=6, req[0] with addr=7 → grant[0]=1, reg_enable=0, addr_err=1 for one cycle; no register changes.
- Reset mid-lock: assert reset while locked with requester 2 → next edge all outputs 0; after release with req=4'b0110, the first grant goes to requester 1.
